// File: rtl/truth_table_probe.sv
// Truth-table probe: walks a 3-input function through all 8 rows, settles,
// samples its response 3x per row and reports majority code plus an error mask.
//   clk, rst_n         : clock, async active-low reset
//   start, abort       : run request / cancel
//   probe_in1..3       : row drive to the function (probe_in1 = MSB)
//   probe_out          : function response
//   busy, done         : run in progress / one-cycle completion pulse
//   code, code_valid   : captured truth table (row 0 -> MSB) and its valid flag
//   err_mask           : rows whose three samples disagreed
module truth_table_probe #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       probe_in1,
  output logic       probe_in2,
  output logic       probe_in3,
  input  logic       probe_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       code_valid,
  output logic [7:0] err_mask
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);

  state_e     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] smp_q, smp_d;
  logic [7:0] code_q, code_d;
  logic [7:0] err_q, err_d;
  logic       valid_q, valid_d;

  logic [2:0] bit_idx;
  logic       maj;
  logic       agree;

  // Row 0 lands in the MSB, so the bit index is 7-row (= ~row on 3 bits).
  assign bit_idx = ~row_q;

  // Third sample is the live input; the first two were stored.
  assign maj = (smp_q[0] & smp_q[1]) |
               (smp_q[0] & probe_out) |
               (smp_q[1] & probe_out);
  assign agree = (smp_q[0] == smp_q[1]) &&
                 (smp_q[1] == probe_out);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    code_d  = code_q;
    err_d   = err_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
          code_d  = 8'h00;
          err_d   = 8'h00;
          valid_d = 1'b0;
        end
      end
      SETTLE, SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
          code_d  = 8'h00;
          err_d   = 8'h00;
          valid_d = 1'b0;
        end else if (state_q == SETTLE) begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = SAMPLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (cnt_q != SAMPLE_LAST) begin
          smp_d[cnt_q[0]] = probe_out;
          cnt_d           = cnt_q + 8'd1;
        end else begin
          code_d[bit_idx] = maj;
          err_d[bit_idx]  = ~agree;
          cnt_d           = 8'd0;
          if (row_q == 3'd7) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            state_d = SETTLE;
            row_d   = row_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = 3'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= 3'd0;
      cnt_q   <= 8'd0;
      smp_q   <= 2'b00;
      code_q  <= 8'h00;
      err_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      code_q  <= code_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign busy = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done = (state_q == DONE);

  assign {probe_in1, probe_in2, probe_in3} = busy ? row_q : 3'b000;

  assign code       = code_q;
  assign err_mask   = err_q;
  assign code_valid = valid_q;

endmodule
